// File: rtl/logic_unit_pkg.sv
// Shared types for the registered bitwise logic unit: op codes and per-beat status flags.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    // Flags travel with the data word; the data width is fixed per instance, so it lives beside this struct.
    typedef struct packed {
        logic zero;
        logic parity;
        logic err;
    } beat_flags_t;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Pure combinational gate array: applies the selected bitwise function and derives the beat flags.
module logic_op_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_data,
    output beat_flags_t      out_flags
);

    logic [WIDTH-1:0] bit_res;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                bit_res[gi] = 1'b0;
                case (op_e'(in_op))
                    OP_AND:  bit_res[gi] = in_a[gi] & in_b[gi];
                    OP_OR:   bit_res[gi] = in_a[gi] | in_b[gi];
                    OP_NOT:  bit_res[gi] = ~in_a[gi];
                    OP_NAND: bit_res[gi] = ~(in_a[gi] & in_b[gi]);
                    OP_NOR:  bit_res[gi] = ~(in_a[gi] | in_b[gi]);
                    OP_XOR:  bit_res[gi] = in_a[gi] ^ in_b[gi];
                    OP_XNOR: bit_res[gi] = ~(in_a[gi] ^ in_b[gi]);
                    default: bit_res[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Illegal op already yields an all-zero word, so zero/parity fall out of the generic reduction.
    always_comb begin
        out_data         = bit_res;
        out_flags.zero   = (bit_res == '0);
        out_flags.parity = ^bit_res;
        out_flags.err    = op_is_illegal(in_op);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, output register plus skid register,
// and a saturating completed-transfer counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] new_data;
    beat_flags_t      new_flags;

    logic             or_valid_reg;
    logic [WIDTH-1:0] or_data_reg;
    beat_flags_t      or_flags_reg;
    logic             sk_valid_reg;
    logic [WIDTH-1:0] sk_data_reg;
    beat_flags_t      sk_flags_reg;
    logic [CNT_W-1:0] done_cnt_reg;

    logic accept;
    logic drain;

    logic_op_comb #(
        .WIDTH(WIDTH)
    ) u_op (
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_data (new_data),
        .out_flags(new_flags)
    );

    // in_ready comes straight from the skid flop, so there is no input-to-ready combinational path.
    assign in_ready = ~sk_valid_reg;
    assign accept   = in_valid & in_ready;
    assign drain    = or_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_reg <= 1'b0;
            or_data_reg  <= '0;
            or_flags_reg <= '0;
            sk_valid_reg <= 1'b0;
            sk_data_reg  <= '0;
            sk_flags_reg <= '0;
        end else if (drain) begin
            if (sk_valid_reg) begin
                or_data_reg  <= sk_data_reg;
                or_flags_reg <= sk_flags_reg;
                sk_valid_reg <= 1'b0;
            end else if (accept) begin
                or_data_reg  <= new_data;
                or_flags_reg <= new_flags;
            end else begin
                or_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!or_valid_reg) begin
                or_valid_reg <= 1'b1;
                or_data_reg  <= new_data;
                or_flags_reg <= new_flags;
            end else begin
                sk_valid_reg <= 1'b1;
                sk_data_reg  <= new_data;
                sk_flags_reg <= new_flags;
            end
        end
    end

    // Clear takes priority over a coincident handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_reg <= '0;
        end else if (cnt_clr) begin
            done_cnt_reg <= '0;
        end else if (drain && done_cnt_reg != CNT_MAX) begin
            done_cnt_reg <= done_cnt_reg + 1'b1;
        end
    end

    assign out_valid  = or_valid_reg;
    assign out_data   = or_data_reg;
    assign out_zero   = or_flags_reg.zero;
    assign out_parity = or_flags_reg.parity;
    assign out_err    = or_flags_reg.err;
    assign done_cnt   = done_cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver queues expected beats on accept, the monitor checks them on output handshakes.
module tb_logic_unit_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       parity;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_parity;
    logic       out_err;
    logic       cnt_clr;
    logic [3:0] done_cnt;

    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic_unit_pipe #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_parity(out_parity),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Holds the beat until accepted; the expected result enters the scoreboard at the accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic z, input logic p, input logic e);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{data: d, zero: z, parity: p, err: e});
                $display("send op=%0d a=%02h b=%02h exp=%02h z=%0b p=%0b e=%0b", op, a, b, d, z, p, e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%02h, expected no beat", out_data);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                if ({out_data, out_zero, out_parity, out_err} !== mon_e) begin
                    errors++;
                    $display("FAIL beat: got d=%02h z=%0b p=%0b e=%0b, expected d=%02h z=%0b p=%0b e=%0b",
                             out_data, out_zero, out_parity, out_err,
                             mon_e.data, mon_e.zero, mon_e.parity, mon_e.err);
                end else begin
                    $display("beat d=%02h z=%0b p=%0b e=%0b", out_data, out_zero, out_parity, out_err);
                end
            end
        end
    end

    initial begin
        int t0;
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_zero, out_parity, out_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: XOR with one-cycle latency
        out_ready = 1'b1;
        send(3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
        check("latency_out_valid", out_valid, 1);

        // Test 2: every op on A5/0F, plus parity/zero corner vectors
        send(3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0);
        send(3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0);
        send(3'd2, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0, 1'b0);
        send(3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0, 1'b0);
        send(3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0);
        send(3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0);
        send(3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0, 1'b0);
        send(3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1);
        send(3'd0, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        send(3'd2, 8'hFE, 8'h77, 8'h01, 1'b0, 1'b1, 1'b0);
        send(3'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        send(3'd4, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Test 3: backpressure fills OR and SK, third beat waits
        out_ready = 1'b0;
        send(3'd0, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready_after_1", in_ready, 1);
        send(3'd1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready_after_2", in_ready, 0);
        fork
            send(3'd6, 8'h0F, 8'h0E, 8'hFE, 1'b0, 1'b1, 1'b0);
            begin
                repeat (2) @(negedge clk);
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_data", out_data, 8'h3C);
                check("bp_still_blocked", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_in_ready_return", in_ready, 1);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Test 4 + 5: clear, then stream 20 beats with no bubbles; counter saturates
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_cleared", done_cnt, 0);
        t0 = $time;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'(i * 8'h0B + 1);
            send(3'd0, 8'hFF, v, v, v == 8'h00, ^v, 1'b0);
        end
        check("stream_cycles", ($time - t0) / 10, 20);
        repeat (2) @(posedge clk);
        #1;
        check("stream_beats", pops - p0, 20);
        check("cnt_saturated", done_cnt, 15);

        // Clear coincident with an output handshake
        send(3'd5, 8'h12, 8'h34, 8'h26, 1'b0, 1'b1, 1'b0);
        check("clr_hs_valid", out_valid, 1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_wins", done_cnt, 0);
        send(3'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("cnt_after_clr", done_cnt, 1);

        // Test 6: reset with OR and SK both full
        out_ready = 1'b0;
        send(3'd1, 8'hAA, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b0);
        send(3'd1, 8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
        check("pre_rst_full", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_done_cnt", done_cnt, 0);
        check("mid_rst_data", {out_data, out_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("no_stale_beat", out_valid, 0);
        @(posedge clk);
        #1;
        send(3'd6, 8'hC3, 8'hC3, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("final_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
